sram_axi_slave: RTL and testbench
=================================

Name: sram_axi_slave

Overview:
AXI4 responder that terminates one slave port of the AXI interconnect and drives a single-port synchronous SRAM macro (IM or DM). It is the opposite end of the CPU-side AXI masters: it accepts AR/AW requests, performs INCR bursts against the SRAM and returns R/B responses. At most one transaction is in flight. Reads and writes are arbitrated round-robin.

Parameters:
ID_W, 8, AXI ID width on the slave side (4-bit master ID plus 4-bit master-select prefix)
ADDR_W, 32, AXI address width
DATA_W, 32, AXI/SRAM data width (fixed 32; 4 byte lanes)
SRAM_AW, 14, SRAM word-address width (16K words)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/4/3/2  read address channel
ARVALID in 1; ARREADY out 1  read address handshake
RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data channel
RVALID out 1; RREADY in 1  read data handshake
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/4/3/2  write address channel
AWVALID in 1; AWREADY out 1  write address handshake
WDATA/WSTRB/WLAST  in  DATA_W/4/1  write data channel
WVALID in 1; WREADY out 1  write data handshake
BID/BRESP  out  ID_W/2  write response
BVALID out 1; BREADY in 1  write response handshake
CEB  out  1  SRAM chip enable, active low
WEB  out  1  SRAM write enable, active low
BWEB  out  DATA_W  SRAM bit write enable, active low
A  out  SRAM_AW  SRAM word address
DI  out  DATA_W  SRAM write data
DO  in  DATA_W  SRAM read data; valid on the cycle after a CEB=0/WEB=1 access

Behaviour:
- Reset (rst=0, async): state=IDLE; ARREADY=AWREADY=WREADY=RVALID=BVALID=0; RDATA=0; RID=BID=0; RRESP=BRESP=0; RLAST=0; CEB=1; WEB=1; BWEB=all 1; A=0; DI=0; last_grant=WRITE, so the first tie goes to read.
- States: IDLE, RD_FETCH, RD_DATA, WR_DATA, WR_RESP.
- IDLE: ARREADY=1 and AWREADY=1 combinationally, gated by arbitration.
  - Only one of ARVALID/AWVALID high: that request is granted.
  - Both high: grant opposite of last_grant. The loser's READY=0 that cycle.
  - Handshake captures ID, ADDR, LEN into registers; beat counter cnt=0; last_grant updated.
  - AR granted -> RD_FETCH. AW granted -> WR_DATA.
- RD_FETCH (1 cycle): CEB=0, WEB=1, A=addr[SRAM_AW+1:2] -> RD_DATA.
- RD_DATA: RVALID=1. RDATA is DO registered on entry and held stable while RVALID && !RREADY. RID=captured ID, RRESP=OKAY, RLAST=(cnt==LEN). CEB=1.
  - RREADY=1 and not last: addr+=4, cnt+=1 -> RD_FETCH.
  - RREADY=1 and last -> IDLE.
  - Read latency: AR handshake at cycle T, first RVALID at T+2. Throughput is 1 beat per 2 cycles.
- WR_DATA: WREADY=1. Each WVALID&&WREADY beat does, in the same cycle: CEB=0, WEB=0, A=addr word index, DI=WDATA, BWEB[8i+7:8i]=~{8{WSTRB[i]}}. Then addr+=4, cnt+=1.
  - Beat with WLAST=1 -> WR_RESP.
  - Cycles without WVALID: CEB=1, no SRAM access.
- WR_RESP: BVALID=1, BID=captured ID, BRESP=OKAY. BREADY=1 -> IDLE.
- Burst rules: AxBURST and AxSIZE are ignored; every burst is INCR of 4-byte words, LEN+1 beats (1..16). The word address wraps modulo 2^SRAM_AW with no error.
- WLAST disagreement:
  - WLAST arrives before cnt==LEN: the burst terminates there.
  - cnt==LEN without WLAST: the burst continues accepting beats until WLAST.
- RVALID, BVALID and payloads stay stable until handshake. No new AR/AW is accepted outside IDLE.
- Reset asserted mid-burst: the transaction is dropped immediately and all outputs return to reset values. A partially written SRAM burst is not rolled back.

Optional Feature:
SRAM_SLV_RANGE_CHK_EN:
- Defined: a request is out of range when addr[ADDR_W-1:SRAM_AW+2] is nonzero; this is checked at AR/AW capture.
  - Out-of-range read: all beats return RDATA=0 and RRESP=SLVERR (2'b10), with CEB held 1.
  - Out-of-range write: beats are accepted with CEB held 1, then BRESP=SLVERR.
  - Handshake timing is unchanged.
- Undefined: upper address bits are ignored and the response is always OKAY.

Test Plan:
- Single write, then read: AW(ID=8'h15, addr=0x0000_0010, LEN=0) with W 0xDEADBEEF, STRB=4'hF -> SRAM write at A=4; BVALID with BID=8'h15, BRESP=0. Then AR same addr -> RVALID at T+2, RDATA=0xDEADBEEF, RLAST=1.
- Byte strobes: pre-fill 0x11223344, write 0xAABBCCDD with STRB=4'b0101 -> BWEB=0xFF00FF00; readback 0x11BB33DD.
- Read burst with backpressure: ARLEN=3 from addr 0x100 over words 0x100..0x10C; RREADY low 3 cycles on beat 1 -> RDATA held stable; 4 beats, RLAST only on the 4th, A increments 64..67.
- Simultaneous ARVALID and AWVALID in IDLE after reset -> read granted first. Then repeated ties alternate W, R, W.
- Async reset mid write burst (after beat 2 of LEN=7) -> next cycle WREADY=0, CEB=1, state IDLE. A new AW is then accepted normally.
- With SRAM_SLV_RANGE_CHK_EN: AR addr 0x0001_0000 -> RRESP=2'b10, RDATA=0, CEB never 0.

Source files
------------

// File: rtl/sram_axi_slave.sv
// AXI4 slave that terminates one interconnect port onto a single-port synchronous SRAM.
// Optional build macro SRAM_SLV_RANGE_CHK_EN: answer SLVERR for addresses beyond the SRAM.
module sram_axi_slave #(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRAM_AW = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ID_W-1:0]      ARID,
  input  logic [ADDR_W-1:0]    ARADDR,
  input  logic [3:0]           ARLEN,
  input  logic [2:0]           ARSIZE,
  input  logic [1:0]           ARBURST,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [ID_W-1:0]      RID,
  output logic [DATA_W-1:0]    RDATA,
  output logic [1:0]           RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY,
  input  logic [ID_W-1:0]      AWID,
  input  logic [ADDR_W-1:0]    AWADDR,
  input  logic [3:0]           AWLEN,
  input  logic [2:0]           AWSIZE,
  input  logic [1:0]           AWBURST,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [DATA_W-1:0]    WDATA,
  input  logic [DATA_W/8-1:0]  WSTRB,
  input  logic                 WLAST,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [ID_W-1:0]      BID,
  output logic [1:0]           BRESP,
  output logic                 BVALID,
  input  logic                 BREADY,
  output logic                 CEB,
  output logic                 WEB,
  output logic [DATA_W-1:0]    BWEB,
  output logic [SRAM_AW-1:0]   A,
  output logic [DATA_W-1:0]    DI,
  input  logic [DATA_W-1:0]    DO
);

  typedef enum logic [2:0] {IDLE, RD_FETCH, RD_DATA, WR_DATA, WR_RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t              state;
  logic                last_wr;
  logic [SRAM_AW-1:0]  waddr;
  logic [3:0]          len;
  logic [3:0]          cnt;
  logic                oor;
  logic                wready_q;
  logic                rd_first;
  logic [DATA_W-1:0]   rdata_q;

  logic idle, tie, ar_hs, aw_hs, w_beat;
  logic ar_oor, aw_oor;
  logic unused_misc;

  assign unused_misc = ^{ARSIZE, ARBURST, AWSIZE, AWBURST, ARADDR[1:0], AWADDR[1:0]};

`ifdef SRAM_SLV_RANGE_CHK_EN
  assign ar_oor = |ARADDR[ADDR_W-1:SRAM_AW+2];
  assign aw_oor = |AWADDR[ADDR_W-1:SRAM_AW+2];
`else
  logic unused_hi;
  assign unused_hi = ^{ARADDR[ADDR_W-1:SRAM_AW+2], AWADDR[ADDR_W-1:SRAM_AW+2]};
  assign ar_oor = 1'b0;
  assign aw_oor = 1'b0;
`endif

  // On a tie the side that did not win last time gets the grant.
  assign idle    = (state == IDLE);
  assign tie     = ARVALID && AWVALID;
  assign ARREADY = rst && idle && !(tie && !last_wr);
  assign AWREADY = rst && idle && !(tie && last_wr);
  assign ar_hs   = ARVALID && ARREADY;
  assign aw_hs   = AWVALID && AWREADY;
  assign WREADY  = wready_q;
  assign w_beat  = WVALID && wready_q;

  // DO is only valid in the first RD_DATA cycle; later cycles replay the captured copy.
  assign RDATA = rd_first ? (oor ? '0 : DO) : rdata_q;
  assign A     = waddr;

  always_comb begin
    CEB  = 1'b1;
    WEB  = 1'b1;
    BWEB = '1;
    DI   = '0;
    if (state == RD_FETCH && !oor) CEB = 1'b0;
    if (w_beat && !oor) begin
      CEB = 1'b0;
      WEB = 1'b0;
      DI  = WDATA;
      for (int i = 0; i < DATA_W/8; i++) BWEB[8*i +: 8] = {8{~WSTRB[i]}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_wr  <= 1'b1;
      waddr    <= '0;
      len      <= '0;
      cnt      <= '0;
      oor      <= 1'b0;
      wready_q <= 1'b0;
      rd_first <= 1'b0;
      rdata_q  <= '0;
      RVALID   <= 1'b0;
      RLAST    <= 1'b0;
      RID      <= '0;
      RRESP    <= RESP_OKAY;
      BVALID   <= 1'b0;
      BID      <= '0;
      BRESP    <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            state   <= RD_FETCH;
            last_wr <= 1'b0;
            waddr   <= ARADDR[SRAM_AW+1:2];
            len     <= ARLEN;
            cnt     <= '0;
            oor     <= ar_oor;
            RID     <= ARID;
          end else if (aw_hs) begin
            state    <= WR_DATA;
            last_wr  <= 1'b1;
            waddr    <= AWADDR[SRAM_AW+1:2];
            len      <= AWLEN;
            cnt      <= '0;
            oor      <= aw_oor;
            BID      <= AWID;
            wready_q <= 1'b1;
          end
        end
        RD_FETCH: begin
          state    <= RD_DATA;
          RVALID   <= 1'b1;
          RLAST    <= (cnt == len);
          RRESP    <= oor ? RESP_SLVERR : RESP_OKAY;
          rd_first <= 1'b1;
        end
        RD_DATA: begin
          if (rd_first) begin
            rd_first <= 1'b0;
            rdata_q  <= oor ? '0 : DO;
          end
          if (RREADY) begin
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
            if (RLAST) begin
              state <= IDLE;
            end else begin
              state <= RD_FETCH;
              waddr <= waddr + 1'b1;
              cnt   <= cnt + 4'd1;
            end
          end
        end
        // WLAST alone ends the burst; the beat count does not.
        WR_DATA: begin
          if (w_beat) begin
            waddr <= waddr + 1'b1;
            cnt   <= cnt + 4'd1;
            if (WLAST) begin
              state    <= WR_RESP;
              wready_q <= 1'b0;
              BVALID   <= 1'b1;
              BRESP    <= oor ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        WR_RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench for sram_axi_slave with a behavioural single-port SRAM model.
module tb_sram_axi_slave;
  localparam int ID_W = 8, ADDR_W = 32, DATA_W = 32, SRAM_AW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ID_W-1:0] ARID = '0, AWID = '0, RID, BID;
  logic [ADDR_W-1:0] ARADDR = '0, AWADDR = '0;
  logic [3:0] ARLEN = '0, AWLEN = '0;
  logic [2:0] ARSIZE = 3'd2, AWSIZE = 3'd2;
  logic [1:0] ARBURST = 2'b01, AWBURST = 2'b01;
  logic ARVALID = 1'b0, AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0;
  logic RREADY = 1'b0, BREADY = 1'b0;
  logic ARREADY, AWREADY, WREADY, RVALID, RLAST, BVALID;
  logic [1:0] RRESP, BRESP;
  logic [DATA_W-1:0] RDATA, WDATA = '0, BWEB, DI, DO;
  logic [3:0] WSTRB = '0;
  logic CEB, WEB;
  logic [SRAM_AW-1:0] A;

  int total = 0;
  int bad = 0;
  int ce_cnt = 0;

  logic [DATA_W-1:0] mem [0:(1<<SRAM_AW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!CEB) begin
      if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
      else DO <= mem[A];
      ce_cnt <= ce_cnt + 1;
    end
  end

  sram_axi_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_AW(SRAM_AW)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input int nb, input logic [31:0] d0, input logic [3:0] strb,
                          input logic [31:0] ebweb, input logic [1:0] eresp);
    logic [SRAM_AW-1:0] ea;
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    #1;
    chk("awready", AWREADY, 1);
    tick;
    AWVALID = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (b == 1) begin
        WVALID = 1'b0;
        #1;
        chk("w_gap_ceb", CEB, 1);
        tick;
      end
      ea = addr[SRAM_AW+1:2] + SRAM_AW'(b);
      WVALID = 1'b1; WDATA = d0 + b; WSTRB = strb; WLAST = (b == nb - 1);
      #1;
      chk("wready", WREADY, 1);
      if (eresp == 2'b00) begin
        chk("w_ceb", CEB, 0);
        chk("w_web", WEB, 0);
        chk("w_a", A, ea);
        chk("w_di", DI, d0 + b);
        chk("w_bweb", BWEB, ebweb);
      end else begin
        chk("w_ceb_oor", CEB, 1);
      end
      tick;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    #1;
    chk("bvalid", BVALID, 1);
    chk("bid", BID, id);
    chk("bresp", BRESP, eresp);
    chk("wready_off", WREADY, 0);
    BREADY = 1'b1;
    tick;
    BREADY = 1'b0;
    chk("bvalid_off", BVALID, 0);
  endtask

  task automatic rd_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [31:0] d0, input logic [1:0] eresp, input int hold_beat);
    logic [SRAM_AW-1:0] ea;
    logic [31:0] ed;
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    #1;
    chk("arready", ARREADY, 1);
    tick;
    ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      ea = addr[SRAM_AW+1:2] + SRAM_AW'(b);
      ed = (eresp == 2'b00) ? d0 + b : 32'h0;
      chk("r_fetch_rvalid", RVALID, 0);
      if (eresp == 2'b00) begin
        chk("r_ceb", CEB, 0);
        chk("r_a", A, ea);
      end else begin
        chk("r_ceb_oor", CEB, 1);
      end
      tick;
      chk("rvalid", RVALID, 1);
      chk("rid", RID, id);
      chk("rresp", RRESP, eresp);
      chk("rdata", RDATA, ed);
      chk("rlast", RLAST, b == int'(len));
      if (b == hold_beat) begin
        repeat (3) begin
          RREADY = 1'b0;
          tick;
          chk("r_hold_valid", RVALID, 1);
          chk("r_hold_data", RDATA, ed);
          chk("r_hold_ceb", CEB, 1);
        end
      end
      RREADY = 1'b1;
      tick;
      RREADY = 1'b0;
    end
    chk("r_done_rvalid", RVALID, 0);
    chk("r_done_arready", ARREADY, 1);
  endtask

  initial begin
    int c0;
    #1 rst = 1'b0;
    #1;
    chk("rst_arready", ARREADY, 0);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_ceb", CEB, 1);
    chk("rst_web", WEB, 1);
    chk("rst_bweb", BWEB, 32'hFFFF_FFFF);
    chk("rst_a", A, 0);
    chk("rst_di", DI, 0);
    #10 rst = 1'b1;
    tick;

    // Ties after reset: read, write, read, write.
    AWID = 8'h2A; AWADDR = 32'h80; AWLEN = 4'd0;
    ARID = 8'h3B; ARADDR = 32'h80; ARLEN = 4'd0;
    for (int k = 0; k < 4; k++) begin
      ARVALID = 1'b1; AWVALID = 1'b1;
      #1;
      chk("tie_arready", ARREADY, (k % 2) == 0);
      chk("tie_awready", AWREADY, (k % 2) == 1);
      tick;
      if (k % 2 == 0) begin
        ARVALID = 1'b0;
        #1;
        chk("rd_blocks_aw", AWREADY, 0);
        tick;
        chk("tie_rid", RID, 8'h3B);
        RREADY = 1'b1;
        tick;
        RREADY = 1'b0;
      end else begin
        AWVALID = 1'b0;
        WVALID = 1'b1; WDATA = 32'(k); WSTRB = 4'hF; WLAST = 1'b1;
        #1;
        chk("wr_blocks_ar", ARREADY, 0);
        tick;
        WVALID = 1'b0; WLAST = 1'b0;
        #1;
        chk("tie_bid", BID, 8'h2A);
        BREADY = 1'b1;
        tick;
        BREADY = 1'b0;
      end
    end
    ARVALID = 1'b0; AWVALID = 1'b0;

    wr_burst(8'h15, 32'h0000_0010, 4'd0, 1, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00);
    rd_burst(8'h15, 32'h0000_0010, 4'd0, 32'hDEAD_BEEF, 2'b00, -1);

    wr_burst(8'h01, 32'h20, 4'd0, 1, 32'h1122_3344, 4'hF, 32'h0, 2'b00);
    wr_burst(8'h02, 32'h20, 4'd0, 1, 32'hAABB_CCDD, 4'b0101, 32'hFF00_FF00, 2'b00);
    rd_burst(8'h03, 32'h20, 4'd0, 32'h11BB_33DD, 2'b00, -1);

    wr_burst(8'h21, 32'h100, 4'd3, 4, 32'hA000_0000, 4'hF, 32'h0, 2'b00);
    rd_burst(8'h22, 32'h100, 4'd3, 32'hA000_0000, 2'b00, 1);

    // Early WLAST ends at 2 beats; late WLAST runs past LEN.
    wr_burst(8'h30, 32'h300, 4'd3, 2, 32'hC000_0000, 4'hF, 32'h0, 2'b00);
    rd_burst(8'h30, 32'h300, 4'd1, 32'hC000_0000, 2'b00, -1);
    wr_burst(8'h31, 32'h400, 4'd0, 3, 32'hD000_0000, 4'hF, 32'h0, 2'b00);
    rd_burst(8'h31, 32'h400, 4'd2, 32'hD000_0000, 2'b00, -1);

    // Word address wraps from the top of the SRAM to zero.
    wr_burst(8'h32, 32'h0000_FFFC, 4'd1, 2, 32'hE000_0000, 4'hF, 32'h0, 2'b00);
    rd_burst(8'h32, 32'h0000_FFFC, 4'd1, 32'hE000_0000, 2'b00, -1);

    // Reset in the middle of an 8-beat write.
    AWID = 8'h50; AWADDR = 32'h200; AWLEN = 4'd7; AWVALID = 1'b1;
    tick;
    AWVALID = 1'b0;
    for (int b = 0; b < 3; b++) begin
      WVALID = 1'b1; WDATA = 32'hF000_0000 + b; WSTRB = 4'hF; WLAST = 1'b0;
      tick;
    end
    WDATA = 32'hF000_0003;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_wready", WREADY, 0);
    chk("mid_rst_ceb", CEB, 1);
    chk("mid_rst_bvalid", BVALID, 0);
    #3 rst = 1'b1;
    WVALID = 1'b0;
    tick;
    wr_burst(8'h51, 32'h40, 4'd0, 1, 32'h5555_AAAA, 4'hF, 32'h0, 2'b00);
    rd_burst(8'h51, 32'h40, 4'd0, 32'h5555_AAAA, 2'b00, -1);
    rd_burst(8'h52, 32'h208, 4'd0, 32'hF000_0002, 2'b00, -1);

`ifdef SRAM_SLV_RANGE_CHK_EN
    c0 = ce_cnt;
    rd_burst(8'h40, 32'h0001_0000, 4'd1, 32'h0, 2'b10, -1);
    wr_burst(8'h41, 32'h0002_0000, 4'd0, 1, 32'h1234_5678, 4'hF, 32'h0, 2'b10);
    chk("oor_no_sram_access", 64'(ce_cnt), 64'(c0));
`else
    c0 = ce_cnt;
    rd_burst(8'h40, 32'h0001_0010, 4'd0, 32'hDEAD_BEEF, 2'b00, -1);
    chk("alias_one_access", 64'(ce_cnt), 64'(c0 + 1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
